// File: rtl/adc_deserializer.sv
// Multi-channel serial ADC front end: convst pulse, conversion wait, then SPI-style shift-in of one frame.
// Optional macro ADC_OFFSET_BINARY_EN inverts each word's MSB on load (offset binary -> two's complement).
module adc_deserializer #(
  parameter int INPUT_WIDTH      = 16,
  parameter int NUM_OF_INPUTS    = 8,
  parameter int SCLK_HALF_PERIOD = 2,
  parameter int CONVST_CYCLES    = 2,
  parameter int CONV_CYCLES      = 10
) (
  input  logic                                          clk,
  input  logic                                          s_rst_n,
  input  logic                                          start,
  input  logic [NUM_OF_INPUTS-1:0]                      adc_sdata,
  output logic                                          adc_convst,
  output logic                                          adc_cs_n,
  output logic                                          adc_sclk,
  output logic signed [NUM_OF_INPUTS-1:0][INPUT_WIDTH-1:0] out,
  output logic                                          ready,
  output logic                                          overrun
);

  // state     | meaning
  // IDLE      | waiting for start
  // CONVST    | adc_convst high for CONVST_CYCLES
  // CONV_WAIT | ADC converting, CONV_CYCLES
  // SHIFT     | cs_n low, INPUT_WIDTH sclk periods, sample on sclk rise
  // DONE      | out loaded, ready pulse
  typedef enum logic [2:0] {IDLE, CONVST, CONV_WAIT, SHIFT, DONE} state_e;

  localparam int TMR_MAX = (CONVST_CYCLES > CONV_CYCLES) ? CONVST_CYCLES : CONV_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int HW      = $clog2(SCLK_HALF_PERIOD + 1);
  localparam int BW      = $clog2(INPUT_WIDTH + 1);

  localparam logic [TW-1:0] CONVST_LOAD = TW'(CONVST_CYCLES - 1);
  localparam logic [TW-1:0] CONV_LOAD   = TW'(CONV_CYCLES - 1);
  localparam logic [HW-1:0] HP_LOAD     = HW'(SCLK_HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LOAD    = BW'(INPUT_WIDTH - 1);

`ifdef ADC_OFFSET_BINARY_EN
  localparam logic [INPUT_WIDTH-1:0] MSB_MASK = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
`else
  localparam logic [INPUT_WIDTH-1:0] MSB_MASK = '0;
`endif

  state_e                                  state_q, state_d;
  logic [TW-1:0]                           tmr_q, tmr_d;
  logic [HW-1:0]                           hp_q, hp_d;
  logic [BW-1:0]                           bit_q, bit_d;
  logic                                    sclk_q, sclk_d;
  logic                                    overrun_q, overrun_d;
  logic [NUM_OF_INPUTS-1:0][INPUT_WIDTH-1:0] shreg_q, shreg_d;
  logic [NUM_OF_INPUTS-1:0][INPUT_WIDTH-1:0] out_q, out_d;

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      hp_q      <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b1;
      overrun_q <= 1'b0;
      shreg_q   <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      hp_q      <= hp_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      overrun_q <= overrun_d;
      shreg_q   <= shreg_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    hp_d      = hp_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    shreg_d   = shreg_q;
    out_d     = out_q;
    // A start landing in DONE is also lost, so it counts as overrun too
    overrun_d = overrun_q | (start && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        sclk_d = 1'b1;
        if (start) begin
          state_d = CONVST;
          tmr_d   = CONVST_LOAD;
        end
      end
      CONVST: begin
        if (tmr_q == '0) begin
          state_d = CONV_WAIT;
          tmr_d   = CONV_LOAD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      CONV_WAIT: begin
        if (tmr_q == '0) begin
          state_d = SHIFT;
          hp_d    = HP_LOAD;
          bit_d   = BIT_LOAD;
          sclk_d  = 1'b0;
          shreg_d = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      SHIFT: begin
        if (hp_q != '0) begin
          hp_d = hp_q - HW'(1);
        end else begin
          hp_d = HP_LOAD;
          if (!sclk_q) begin
            // This edge is the sclk low->high edge, so data is captured here
            sclk_d = 1'b1;
            for (int i = 0; i < NUM_OF_INPUTS; i++) begin
              shreg_d[i] = {shreg_q[i][INPUT_WIDTH-2:0], adc_sdata[i]};
            end
          end else if (bit_q == '0) begin
            state_d = DONE;
            for (int i = 0; i < NUM_OF_INPUTS; i++) begin
              out_d[i] = shreg_q[i] ^ MSB_MASK;
            end
          end else begin
            bit_d  = bit_q - BW'(1);
            sclk_d = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        sclk_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        sclk_d  = 1'b1;
      end
    endcase
  end

  assign adc_convst = (state_q == CONVST);
  assign adc_cs_n   = (state_q != SHIFT);
  assign adc_sclk   = sclk_q;
  assign ready      = (state_q == DONE);
  assign overrun    = overrun_q;
  assign out        = out_q;

endmodule
